// File: rtl/elevator_request_queue.sv
// Elevator request queue: debounces the hall-up, hall-down and car buttons of
// FLOORS floors and latches each accepted press into a sticky queue bit. The
// controller clears queue bits as it serves floors and reads the above, below
// and here summaries plus a pending-request count.
//
// Each button is one channel. Channels are ordered bottom to top:
// 0 .. FLOORS-1 are hall up, FLOORS .. 2*FLOORS-1 are hall down,
// and 2*FLOORS .. 3*FLOORS-1 are car buttons.
module elevator_request_queue #(
    parameter int FLOORS   = 4,
    parameter int DEBOUNCE = 4,
    parameter int FW       = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [FLOORS-1:0]                 outsideUp,
    input  logic [FLOORS-1:0]                 outsideDown,
    input  logic [FLOORS-1:0]                 insideFloor,
    input  logic [FW-1:0]                     curFloor,
    input  logic                              serviceValid,
    input  logic                              serviceUp,
    input  logic                              serviceDown,
    output logic [FLOORS-1:0]                 queueUp,
    output logic [FLOORS-1:0]                 queueDown,
    output logic [FLOORS-1:0]                 queueInside,
    output logic                              reqAbove,
    output logic                              reqBelow,
    output logic                              reqHere,
    output logic [$clog2(3*FLOORS+1)-1:0]     pendingCount
);

    localparam int CH  = 3 * FLOORS;
    localparam int CW  = $clog2(DEBOUNCE + 1);
    localparam int PCW = $clog2(3 * FLOORS + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_PRE = CW'(DEBOUNCE - 1);
    localparam logic [FW:0]   FLOORS_W = (FW + 1)'(FLOORS);

    // The top floor has no up button and the bottom floor has no down button.
    function automatic logic [CH-1:0] legalMask();
        logic [CH-1:0] m;
        m             = '1;
        m[FLOORS-1]   = 1'b0;
        m[FLOORS]     = 1'b0;
        return m;
    endfunction

    localparam logic [CH-1:0] LEGAL = legalMask();

    logic [CH-1:0]     rawBtn;
    logic [CW-1:0]     cnt [CH];
    logic [CH-1:0]     armed;
    logic [CH-1:0]     preEdge;
    logic [CH-1:0]     accept;

    logic              curValid;
    logic [FLOORS-1:0] hereMask;
    logic [FLOORS-1:0] aboveMask;
    logic [FLOORS-1:0] belowMask;
    logic [FLOORS-1:0] clrMask;
    logic [FLOORS-1:0] anyReq;

    assign rawBtn   = {insideFloor, outsideDown, outsideUp};
    assign curValid = ({1'b0, curFloor} < FLOORS_W);

    // Find channels about to reach the debounce threshold on this edge; only
    // armed, legal ones count as a press.
    always_comb begin
        preEdge = '0;
        for (int ch = 0; ch < CH; ch++) begin
            preEdge[ch] = rawBtn[ch] && (cnt[ch] == CNT_PRE);
        end
        accept = preEdge & armed & LEGAL;
    end

    // Per-channel debounce: count consecutive high samples up to the threshold,
    // and disarm at the threshold so a held button registers once. A low sample
    // restarts the count and re-arms the channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < CH; ch++) begin
                cnt[ch] <= '0;
            end
            armed <= '1;
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                if (!rawBtn[ch]) begin
                    cnt[ch]   <= '0;
                    armed[ch] <= 1'b1;
                end else begin
                    if (cnt[ch] != CNT_MAX) begin
                        cnt[ch] <= cnt[ch] + CW'(1);
                    end
                    if (preEdge[ch]) begin
                        armed[ch] <= 1'b0;
                    end
                end
            end
        end
    end

    // Decode the current floor into one-hot here, above and below masks. An
    // out-of-range floor counts as being above every real floor.
    always_comb begin
        hereMask  = '0;
        aboveMask = '0;
        belowMask = '0;
        for (int i = 0; i < FLOORS; i++) begin
            hereMask[i]  = curValid && (curFloor == FW'(i));
            aboveMask[i] = curValid && (curFloor < FW'(i));
            belowMask[i] = !curValid || (curFloor > FW'(i));
        end
        clrMask = hereMask & {FLOORS{serviceValid}};
    end

    // Sticky queues: accepted presses set bits, service at the current floor
    // clears them. Clear is applied last so a press landing on the serviced
    // floor in the same cycle is treated as already satisfied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queueUp     <= '0;
            queueDown   <= '0;
            queueInside <= '0;
        end else begin
            queueUp     <= (queueUp | accept[FLOORS-1:0])
                           & ~(clrMask & {FLOORS{serviceUp}});
            queueDown   <= (queueDown | accept[2*FLOORS-1:FLOORS])
                           & ~(clrMask & {FLOORS{serviceDown}});
            queueInside <= (queueInside | accept[3*FLOORS-1:2*FLOORS])
                           & ~clrMask;
        end
    end

    assign anyReq   = queueUp | queueDown | queueInside;
    assign reqHere  = |(anyReq & hereMask);
    assign reqAbove = |(anyReq & aboveMask);
    assign reqBelow = |(anyReq & belowMask);

    // Count every set queue bit across the three queues.
    always_comb begin
        pendingCount = '0;
        for (int i = 0; i < FLOORS; i++) begin
            pendingCount = pendingCount + PCW'(queueUp[i]);
            pendingCount = pendingCount + PCW'(queueDown[i]);
            pendingCount = pendingCount + PCW'(queueInside[i]);
        end
    end

endmodule
